// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq - iterative shift-add multiply sequencer
//
// Computes the low word of a*b (ARM MUL) in a fixed WIDTH+1 cycles so that
// the single-cycle ALU can stay free of a combinational multiplier. The
// controlling FSM pulses start, stalls while busy is high, and writes back
// result when done pulses. N/Z flag values for the completed product are
// also supplied; S-bit gating is left to the decoder.
//
// Optional feature (macro MUL_SEQ_LONG_EN):
//   defined   - the accumulator is 2*WIDTH bits wide, result_hi carries the
//               UMULL high word and flags cover the full 2*WIDTH product.
//   undefined - the datapath is WIDTH bits wide, result_hi is tied to 0 and
//               flags cover the low word only.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   start      in   1      request a multiply (accepted in IDLE or DONE)
//   a          in   WIDTH  multiplicand (Rn), captured on accept
//   b          in   WIDTH  multiplier (Rm), captured on accept
//   busy       out  1      high while iterating; stalls the main FSM
//   done       out  1      one-cycle pulse when result is valid
//   result     out  WIDTH  low WIDTH bits of a*b
//   result_hi  out  WIDTH  high WIDTH bits of a*b (0 unless MUL_SEQ_LONG_EN)
//   flag_n     out  1      negative flag of the completed product
//   flag_z     out  1      zero flag of the completed product
// ---------------------------------------------------------------------------
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

`ifdef MUL_SEQ_LONG_EN
    localparam int unsigned AW = 2 * WIDTH;
`else
    localparam int unsigned AW = WIDTH;
`endif
    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    logic [AW-1:0]    mcand_init;
    logic [AW-1:0]    acc_step;

    // Multiplicand zero-extended to the accumulator width on capture.
`ifdef MUL_SEQ_LONG_EN
    assign mcand_init = {{WIDTH{1'b0}}, a};
`else
    assign mcand_init = a;
`endif

    // One shift-add step; carry out of the top bit is intentionally dropped.
    always_comb begin
        acc_step = acc;
        if (mplier[0]) begin
            acc_step = acc + mcand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        mcand  <= mcand_init;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= StDone;
                        // Flags latch from the final product so they hold
                        // (and read 0 after reset) independent of acc.
                        flag_n <= acc_step[AW-1];
                        flag_z <= (acc_step == '0);
                    end
                end
                StDone: begin
                    if (start) begin
                        mcand  <= mcand_init;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign busy   = (state == StRun);
    assign done   = (state == StDone);
    assign result = acc[WIDTH-1:0];

`ifdef MUL_SEQ_LONG_EN
    assign result_hi = acc[AW-1:WIDTH];
`else
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_seq - self-checking bench for mul_seq (WIDTH = 32).
// Expected values come from a plain arithmetic product model.
// ---------------------------------------------------------------------------
module tb_mul_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_n;
    logic         flag_z;

    int checks   = 0;
    int failures = 0;

    mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width unsigned product, then select per build.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic n, output logic z);
        logic [2*W-1:0] p;
        p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        lo = p[W-1:0];
`ifdef MUL_SEQ_LONG_EN
        hi = p[2*W-1:W];
        n  = p[2*W-1];
        z  = (p == '0);
`else
        hi = '0;
        n  = p[W-1];
        z  = (p[W-1:0] == '0);
`endif
    endfunction

    // Present operands for exactly one rising edge; returns at the first
    // sample after the accepting edge. Operands are then scrambled.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called at the first sample after accept (cycle 1). Returns at the
    // sample where done is seen; done_at = 0 means the bound expired.
    // Optionally pulses start with (pa, pb) at cycle pulse_at.
    task automatic wait_done(input int pulse_at, input logic [W-1:0] pa,
                             input logic [W-1:0] pb,
                             output int done_at, output int busy_cnt);
        done_at  = 0;
        busy_cnt = 0;
        for (int n = 1; n <= W + 10; n++) begin
            if (done) begin
                done_at = n;
                break;
            end
            if (busy) busy_cnt++;
            if (n == pulse_at) begin
                start = 1'b1;
                a     = pa;
                b     = pb;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // One full multiply: latency, busy width, product, flags, and hold.
    task automatic test_product(input string tag, input logic [W-1:0] x,
                                input logic [W-1:0] y);
        logic [W-1:0] e_lo, e_hi;
        logic         e_n, e_z;
        int           d, bc;
        model(x, y, e_lo, e_hi, e_n, e_z);
        issue(x, y);
        wait_done(0, '0, '0, d, bc);
        checks++;
        if (d !== W + 1) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", tag, d, W + 1);
        end
        checks++;
        if (bc !== W) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, bc, W);
        end
        checks++;
        if (result !== e_lo || result_hi !== e_hi) begin
            failures++;
            $display("FAIL %s_result: got %h_%h expected %h_%h (a=%h b=%h)",
                     tag, result_hi, result, e_hi, e_lo, x, y);
        end
        checks++;
        if (flag_n !== e_n || flag_z !== e_z) begin
            failures++;
            $display("FAIL %s_flags: got n=%b z=%b expected n=%b z=%b",
                     tag, flag_n, flag_z, e_n, e_z);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== e_lo || flag_z !== e_z) begin
            failures++;
            $display("FAIL %s_hold: got done=%b busy=%b result=%h z=%b expected 0 0 %h %b",
                     tag, done, busy, result, flag_z, e_lo, e_z);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, flag_n, flag_z} !== 4'b0000 || result !== '0 || result_hi !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b n=%b z=%b result=%h hi=%h expected all 0",
                     busy, done, flag_n, flag_z, result, result_hi);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        test_product("basic", 32'd3, 32'd5);
        checks++;
        if (result !== 32'h0000_000F) begin
            failures++;
            $display("FAIL basic_const: got %h expected 0000000f", result);
        end
    endtask

    task automatic test_wrap();
        test_product("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_product("neg_msb", 32'h8000_0000, 32'd1);
    endtask

    task automatic test_zero();
        test_product("zero", 32'd0, 32'h1234_5678);
    endtask

    task automatic test_start_while_busy();
        int d, bc;
        issue(32'd7, 32'd6);
        wait_done(6, 32'd9, 32'd9, d, bc);
        checks++;
        if (d !== W + 1 || bc !== W) begin
            failures++;
            $display("FAIL busy_start_timing: got done=%0d busy=%0d expected %0d %0d",
                     d, bc, W + 1, W);
        end
        checks++;
        if (result !== 32'd42) begin
            failures++;
            $display("FAIL busy_start_result: got %0d expected 42", result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y, e_lo, e_hi;
        logic         e_n, e_z;
        int           d, bc;
        x = $urandom;
        y = $urandom;
        model(x, y, e_lo, e_hi, e_n, e_z);
        issue(x, y);
        wait_done(0, '0, '0, d, bc);
        checks++;
        if (d !== W + 1 || result !== e_lo) begin
            failures++;
            $display("FAIL b2b_first: got done=%0d result=%h expected %0d %h", d, result, W + 1, e_lo);
        end
        // Request the next op during the DONE cycle.
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd10;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got done=%b busy=%b expected 0 1", done, busy);
        end
        wait_done(0, '0, '0, d, bc);
        checks++;
        if (d !== W + 1 || result !== 32'd20) begin
            failures++;
            $display("FAIL b2b_second: got done=%0d result=%0d expected %0d 20", d, result, W + 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_reset_mid_run();
        // Leave flag_z set so the reset clearing it is observable.
        test_product("pre_reset", 32'd0, 32'd5);
        issue(32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result === '0) begin
            failures++;
            $display("FAIL midrun_active: got busy=%b result=%h expected busy=1 result nonzero",
                     busy, result);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, flag_n, flag_z} !== 4'b0000 || result !== '0 || result_hi !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b n=%b z=%b result=%h hi=%h expected all 0",
                     busy, done, flag_n, flag_z, result, result_hi);
        end
        @(negedge clk);
        reset = 1'b0;
        test_product("after_reset", 32'd4, 32'd4);
        checks++;
        if (result !== 32'd16) begin
            failures++;
            $display("FAIL after_reset_const: got %0d expected 16", result);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i == 3) y = '0;
            if (i == 5) x = 32'h0001_0000;
            if (i == 5) y = 32'h0001_0000;
            test_product("random", x, y);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Iterative shift-add multiply sequencer for the multicycle ARM datapath. It performs MUL (low word of the product) over WIDTH cycles, so the single-cycle ALU does not need a combinational multiplier. The main FSM issues a start pulse, holds its state while busy is high, and writes result back when done pulses. The block also supplies the N/Z values for the flag logic when the S bit is set.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled on the rising clk edge
a  input  WIDTH  multiplicand (Rn), captured when start is accepted
b  input  WIDTH  multiplier (Rm), captured when start is accepted
busy  output  1  high while the multiply is iterating; FSM stall
done  output  1  single-cycle pulse when result becomes valid
result  output  WIDTH  low WIDTH bits of a*b (unsigned, which equals signed for the low word)
result_hi  output  WIDTH  high WIDTH bits of the product (see Optional Feature)
flag_n  output  1  negative flag value for the completed product
flag_z  output  1  zero flag value for the completed product

Behaviour:
- State machine: IDLE, RUN, DONE. Internal registers:
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - acc: 2*WIDTH bits.
  - cnt: $clog2(WIDTH+1) bits.
- Reset (asynchronous) clears all of the following, with immediate effect including mid-RUN:
  - state=IDLE
  - acc=0, cnt=0
  - busy=0, done=0
  - result=0, result_hi=0
  - flag_n=0, flag_z=0
- IDLE, start=1 at an edge: mcand={0,a}, mplier=b, acc=0, cnt=0, state becomes RUN. IDLE with start=0: hold.
- RUN, each edge:
  - If mplier[0]=1, acc is updated to acc+mcand (2*WIDTH-bit add, no carry-out kept).
  - mcand shifts left by 1; mplier shifts right by 1 (logical); cnt increments.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th RUN edge), the final step is applied and state becomes DONE.
  - No early termination; latency is fixed.
- DONE lasts exactly one cycle, then goes to IDLE, unless start=1 on that edge, in which case it goes to RUN with new operands captured (back-to-back).
- Outputs are decoded from state and registers:
  - busy = (state==RUN).
  - done = (state==DONE).
  - result = acc[WIDTH-1:0].
  - result_hi per the Optional Feature.
  - result is valid from the DONE cycle and holds through IDLE until the next accepted start. During RUN it shows partial values and must not be consumed.
- Latency: start sampled at edge E0 gives busy high for WIDTH cycles (E0..E_WIDTH) and done high in the cycle after edge E_WIDTH. That is WIDTH+1 cycles from accept to done.
- start while in RUN: ignored; no operand capture, no effect on the sequence.
- a and b may change freely after the accepting edge.
- Flags, taken from the completed product:
  - flag_n = MSB of the returned product.
  - flag_z = 1 when the returned product is all zero.
  - The S-bit gating (FlagW) stays in decode; this block does not gate flags.

Optional Feature:
Macro MUL_SEQ_LONG_EN.
- Defined:
  - result_hi = acc[2*WIDTH-1:WIDTH] (UMULL high word).
  - flag_n = acc[2*WIDTH-1].
  - flag_z = (acc == 0) over all 2*WIDTH bits.
- Undefined:
  - result_hi is tied to 0.
  - acc, mcand and the adder shrink to WIDTH bits.
  - flag_n = acc[WIDTH-1].
  - flag_z = (acc[WIDTH-1:0] == 0).
- Latency and handshake are identical in both builds.

Test Plan:
- Basic product: reset, then start with a=3, b=5 → busy high for 32 cycles; done pulses in cycle 33 after accept; result=0x0000000F, flag_n=0, flag_z=0; result holds after done drops.
- Wrap and negative: a=0xFFFFFFFF, b=0xFFFFFFFF → result=0x00000001, flag_n=0. With MUL_SEQ_LONG_EN: result_hi=0xFFFFFFFE, flag_n=1. Also a=0x80000000, b=1 → result=0x80000000, flag_n=1 (non-long build).
- Zero product: a=0, b=0x12345678 → result=0, flag_z=1, full 33-cycle latency still observed.
- Start while busy: accept a=7, b=6, then pulse start with a=9, b=9 mid-RUN → ignored; done at the original cycle with result=42.
- Back-to-back: start=1 with a=2, b=10 during the DONE cycle of a prior op → done pulses for exactly one cycle, busy rises next cycle, second done 33 cycles later with result=20.
- Reset mid-run: assert reset at RUN cycle 10 → busy, done, result and flags are 0 immediately (asynchronously); after release, a new start with a=4, b=4 yields 16.
